compare_iter: RTL and testbench

COMPARE_ITER -- requirements
Module: compare_iter

---
 rtl/compare_iter.sv | 134 +++++++++++++
 tb/tb_compare_iter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/compare_iter.sv
// Iterative slice-serial comparator for SLT/SLTU/SEQ/SNE.
// COMPARE_EARLY_EXIT_EN: finish on the first differing slice.
module compare_iter #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] rd_o
);

  localparam int NCH = XLEN / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] OP_SLT  = 2'b00;
  localparam logic [1:0] OP_SLTU = 2'b01;
  localparam logic [1:0] OP_SEQ  = 2'b10;
  localparam logic [1:0] OP_SNE  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] a_q, b_q, rd_q;
  logic [1:0]      op_q;
  logic [IW-1:0]   idx_q;

  logic [CHUNK-1:0] a_sl [NCH];
  logic [CHUNK-1:0] b_sl [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_sl
    assign a_sl[i] = a_q[i*CHUNK +: CHUNK];
    assign b_sl[i] = b_q[i*CHUNK +: CHUNK];
  end

  logic [CHUNK-1:0] sa, sb;
  logic diff, lt, any_diff, any_lt, last, res;

`ifndef COMPARE_EARLY_EXIT_EN
  logic found_q, lt_q;
`endif

  always_comb begin
    sa = a_sl[idx_q];
    sb = b_sl[idx_q];
    // Flipping the sign bit maps two's-complement order onto unsigned order
    if (op_q == OP_SLT && idx_q == IW'(NCH-1)) begin
      sa[CHUNK-1] = ~sa[CHUNK-1];
      sb[CHUNK-1] = ~sb[CHUNK-1];
    end
    diff = (sa != sb);
    lt   = (sa < sb);
`ifdef COMPARE_EARLY_EXIT_EN
    any_diff = diff;
    any_lt   = lt;
    last     = diff || (idx_q == '0);
`else
    any_diff = found_q || diff;
    any_lt   = found_q ? lt_q : lt;
    last     = (idx_q == '0);
`endif
    case (op_q)
      OP_SLT,
      OP_SLTU: res = any_lt;
      OP_SEQ:  res = ~any_diff;
      OP_SNE:  res = any_diff;
      default: res = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ready_o = (state_q == IDLE);
    valid_o = (state_q == DONE);
    case (state_q)
      IDLE:    if (valid_i) state_d = BUSY;
      BUSY:    if (last)    state_d = DONE;
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      idx_q <= '0;
      rd_q  <= '0;
`ifndef COMPARE_EARLY_EXIT_EN
      found_q <= 1'b0;
      lt_q    <= 1'b0;
`endif
    end else if (state_q == IDLE && valid_i) begin
      a_q   <= rs1_i;
      b_q   <= rs2_i;
      op_q  <= op_i;
      idx_q <= IW'(NCH-1);
`ifndef COMPARE_EARLY_EXIT_EN
      found_q <= 1'b0;
      lt_q    <= 1'b0;
`endif
    end else if (state_q == BUSY) begin
      if (last) rd_q  <= {{(XLEN-1){1'b0}}, res};
      else      idx_q <= idx_q - IW'(1);
`ifndef COMPARE_EARLY_EXIT_EN
      // Latch the verdict of the most significant differing slice only
      if (!found_q && diff) begin
        found_q <= 1'b1;
        lt_q    <= lt;
      end
`endif
    end
  end

  assign rd_o = rd_q;

endmodule

// File: tb/tb_compare_iter.sv
// Scoreboard bench for compare_iter (XLEN=32, CHUNK=8).
// Honors COMPARE_EARLY_EXIT_EN for expected latency.
module tb_compare_iter;

  localparam int XLEN  = 32;
  localparam int CHUNK = 8;
  localparam int NCH   = XLEN / CHUNK;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            valid_i;
  logic            ready_o;
  logic [1:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] rd_o;

  typedef struct {
    logic [XLEN-1:0] rd;
    int              lat;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  compare_iter #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .rs1_i   (rs1_i),
    .rs2_i   (rs2_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .rd_o    (rd_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [XLEN-1:0] model_rd(
    input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic r;
    case (op)
      2'b00:   r = ($signed(a) < $signed(b));
      2'b01:   r = (a < b);
      2'b10:   r = (a == b);
      default: r = (a != b);
    endcase
    return {{(XLEN-1){1'b0}}, r};
  endfunction

  function automatic int model_lat(
    input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
`ifdef COMPARE_EARLY_EXIT_EN
    for (int j = NCH - 1; j >= 0; j--)
      if (a[j*CHUNK +: CHUNK] != b[j*CHUNK +: CHUNK]) return NCH - j;
`endif
    return NCH;
  endfunction

  task automatic run_req(input logic [1:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input int hold);
    exp_t e;
    logic [XLEN-1:0] held;
    int k;
    @(negedge clk_i);
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    valid_i = 1'b1;
    ready_i = 1'b0;
    e.rd  = model_rd(op, a, b);
    e.lat = model_lat(a, b);
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    op_i  = 2'($urandom);
    rs1_i = $urandom;
    rs2_i = $urandom;
    k = 0;
    while (!valid_o && k < 40) begin
      @(posedge clk_i);
      #1;
      k++;
    end
    valid_i = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (valid_o !== 1'b1 || k != e.lat) begin
      errors++;
      $display("FAIL latency op=%0d a=%h b=%h got=%0d valid=%b want=%0d",
               op, a, b, k, valid_o, e.lat);
    end
    checks++;
    if (rd_o !== e.rd) begin
      errors++;
      $display("FAIL result op=%0d a=%h b=%h got=%h want=%h", op, a, b, rd_o, e.rd);
    end
    held = rd_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i);
      #1;
      checks++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || rd_o !== held) begin
        errors++;
        $display("FAIL hold cyc=%0d valid=%b ready=%b rd=%h want valid=1 ready=0 rd=%h",
                 i, valid_o, ready_o, rd_o, held);
      end
    end
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || rd_o !== e.rd) begin
      errors++;
      $display("FAIL handshake ready=%b valid=%b rd=%h want ready=1 valid=0 rd=%h",
               ready_o, valid_o, rd_o, e.rd);
    end
  endtask

  task automatic test_reset;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    op_i    = '0;
    rs1_i   = '0;
    rs2_i   = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || rd_o !== '0) begin
      errors++;
      $display("FAIL reset ready=%b valid=%b rd=%h want 1 0 0", ready_o, valid_o, rd_o);
    end
  endtask

  task automatic test_directed;
    run_req(2'b00, 32'hFFFFFFFF, 32'h00000001, 0);
    run_req(2'b01, 32'hFFFFFFFF, 32'h00000001, 0);
    run_req(2'b10, 32'h12345678, 32'h12345678, 0);
    run_req(2'b11, 32'h12345678, 32'h12345678, 0);
    run_req(2'b00, 32'h00000100, 32'h00000101, 0);
    run_req(2'b00, 32'h80000000, 32'h7FFFFFFF, 0);
    run_req(2'b01, 32'h80000000, 32'h7FFFFFFF, 0);
    run_req(2'b00, 32'h7FFFFFFF, 32'h80000000, 0);
    run_req(2'b10, 32'h12345678, 32'h12345679, 0);
    run_req(2'b11, 32'h12340000, 32'h12350000, 0);
    run_req(2'b01, 32'h00AB0000, 32'h00AA00FF, 0);
  endtask

  task automatic test_backpressure;
    run_req(2'b00, 32'hFFFFFF00, 32'h00000005, 3);
    run_req(2'b10, 32'hCAFEBABE, 32'hCAFEBABE, 3);
  endtask

  task automatic test_reset_busy;
    int seen;
    run_req(2'b10, 32'h0000_0042, 32'h0000_0042, 0);
    @(negedge clk_i);
    op_i    = 2'b10;
    rs1_i   = 32'h5555AAAA;
    rs2_i   = 32'h5555AAAA;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    rst_i   = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || rd_o !== '0) begin
      errors++;
      $display("FAIL reset_busy ready=%b valid=%b rd=%h want 1 0 0",
               ready_o, valid_o, rd_o);
    end
    seen = 0;
    repeat (8) begin
      @(posedge clk_i);
      #1;
      if (valid_o === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL discard valid_cycles=%0d want 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    logic [XLEN-1:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      case (i % 4)
        0: b = a;
        1: b = {a[31:8], b[7:0]};
        2: b = {a[31:16], b[15:0]};
        default: ;
      endcase
      run_req(2'(i), a, b, i % 2);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_busy;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
